mcb_frame_writer: RTL and testbench
===================================

MCB_FRAME_WRITER -- requirements
Module: mcb_frame_writer

Interface
- REQ-001 Parameter: DATA_W, 64, MCB port data width in bits; allowed values 32 or 64.
- REQ-002 Parameter: MAX_BL, 32, maximum words per write burst; allowed range 1..64.
- REQ-003 Parameter: FRAME_WORDS, 8820, words per frame.
- REQ-004 Parameter: BASE_A, 0, byte address of buffer A (30 bits).
- REQ-005 Parameter: BASE_B, 70560, byte address of buffer B (30 bits).
- REQ-006 Parameter: FLUSH_CYCLES, 255, idle cycles before a partial burst is flushed.
- REQ-007 Port: clk0  in  1  MCB user clock; the only clock.
- REQ-008 Port: reset  in  1  asynchronous, active-high.
- REQ-009 Port: calib_done  in  1  MCB calibration complete; asynchronous to clk0.
- REQ-010 Port: src_valid  in  1  source word valid.
- REQ-011 Port: src_data  in  DATA_W  source word.
- REQ-012 Port: src_last  in  1  marks the final word of a frame; qualified by src_valid.
- REQ-013 Port: src_ready  out  1  block accepts the source word this cycle.
- REQ-014 Port: cmd_en, cmd_instr, cmd_bl, cmd_byte_addr  out  1, 3, 6, 30  MCB command port.
- REQ-015 Port: wr_en, wr_data, wr_mask  out  1, DATA_W, DATA_W/8  MCB write FIFO.
- REQ-016 Port: wr_full, wr_empty  in  1, 1  MCB write FIFO status.
- REQ-017 Port: disp_buf  out  1  last completed buffer (0 = A, 1 = B).
- REQ-018 Port: frame_done  out  1  one-cycle pulse when a frame is fully committed.
- REQ-019 Port: err_ovf  out  1  sticky flag: frame exceeded FRAME_WORDS.

Function
- REQ-020 calib_done SHALL pass through a 2-flop synchronizer; the state machine leaves CAL only when the synchronized value is 1.
- REQ-021 States: CAL -> FILL -> CMD -> DRAIN -> FILL. No other transitions exist apart from reset.
- REQ-022 In FILL, src_ready = !wr_full && cnt < lim, where lim = min(MAX_BL, FRAME_WORDS - word_off).
- REQ-023 On each accept, the next cycle SHALL drive wr_en = 1, wr_data = src_data, wr_mask = 0, and cnt SHALL increment.
- REQ-024 FILL -> CMD occurs on the cycle after any of: cnt reaches lim; src_last is accepted; the flush condition fires (REQ-040).
- REQ-025 CMD lasts one cycle and drives cmd_en = 1, cmd_instr = 3'b000, cmd_bl = cnt - 1, cmd_byte_addr = base + word_off*(DATA_W/8).
- REQ-026 base SHALL be BASE_A when wr_buf = 0 and BASE_B otherwise.
- REQ-027 In CMD, word_off SHALL advance by cnt and cnt SHALL clear to 0.
- REQ-028 DRAIN holds until wr_empty = 1, then returns to FILL.
- REQ-029 A burst SHALL close the frame if it contained src_last or brought word_off to FRAME_WORDS. On that DRAIN exit: disp_buf <= wr_buf, wr_buf toggles, word_off <= 0, frame_done pulses for one cycle.
- REQ-030 If the frame closes by reaching FRAME_WORDS without src_last, the next accepted word (in the following frame) SHALL set err_ovf when it carries src_last = 0 and that frame's count diverges; err_ovf clears only on reset.
- REQ-031 A src_last accepted on the same cycle that cnt reaches lim SHALL produce exactly one CMD and one frame close.
- REQ-032 cmd_en SHALL never assert with cnt = 0.
- REQ-033 No command SHALL be issued while wr_en is still pending.

Reset
- REQ-034 While reset = 1: state = CAL, synchronizer = 0, cnt = 0, word_off = 0, wr_buf = 0.
- REQ-035 While reset = 1: all outputs 0, except disp_buf = 1 (buffer B is shown before the first frame completes).
- REQ-036 Assertion of reset in any state SHALL abort the in-progress operation immediately; no partial command is issued.

Configuration
- REQ-037 Macro MCB_FW_FLUSH_TIMEOUT_EN selects partial-burst flushing.
- REQ-038 With the macro defined, an 8-bit idle counter runs while in FILL with cnt > 0.
- REQ-039 The idle counter SHALL clear on every accept.
- REQ-040 When the idle counter reaches FLUSH_CYCLES, the flush condition fires and FILL -> CMD with the current cnt.
- REQ-041 Without the macro, the counter logic is absent and partial bursts wait indefinitely for MAX_BL or src_last.

Verification
- REQ-042 Scenario: calib_done held at 0, src_valid = 1 -> src_ready = 0, no wr_en and no cmd_en; calib_done rises -> src_ready = 1 within 3 cycles.
- REQ-043 Scenario: 64 consecutive words, MAX_BL = 32, DATA_W = 64 -> two commands, cmd_bl = 31 each, cmd_byte_addr = 0 then 256.
- REQ-044 Scenario: src_last on word 5 of a frame -> cmd_bl = 4; frame_done pulses once; disp_buf = 0; the next command addresses 70560.
- REQ-045 Scenario: wr_empty held at 0 for 100 cycles after CMD -> src_ready = 0 for that whole window.
- REQ-046 Scenario: 3 words then 300 idle cycles, macro defined -> cmd_bl = 2 issued after 255 idle cycles; macro undefined -> no command issued.
- REQ-047 Scenario: reset asserted mid-FILL with cnt = 10 -> all outputs reset; no cmd_en; the next frame starts at address 0.

Source files
------------

// File: rtl/mcb_frame_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : mcb_frame_writer_if
// Description : Source stream, MCB command port and MCB write-FIFO bundle.
// Revision    : 1.0
// ============================================================================
interface mcb_frame_writer_if #(
   parameter int DATA_W = 64
);
   logic                  src_valid;
   logic [DATA_W-1:0]     src_data;
   logic                  src_last;
   logic                  src_ready;
   logic                  cmd_en;
   logic [2:0]            cmd_instr;
   logic [5:0]            cmd_bl;
   logic [29:0]           cmd_byte_addr;
   logic                  wr_en;
   logic [DATA_W-1:0]     wr_data;
   logic [DATA_W/8-1:0]   wr_mask;
   logic                  wr_full;
   logic                  wr_empty;

   modport slave (
      input  src_valid, src_data, src_last, wr_full, wr_empty,
      output src_ready, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
             wr_en, wr_data, wr_mask
   );

   modport master (
      output src_valid, src_data, src_last, wr_full, wr_empty,
      input  src_ready, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
             wr_en, wr_data, wr_mask
   );
endinterface
`default_nettype wire

// File: rtl/mcb_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : mcb_frame_writer
// Description : Packs a source word stream into MCB write bursts, ping-ponging
//               whole frames between buffers A and B.
//               Optional macro MCB_FW_FLUSH_TIMEOUT_EN flushes idle partial bursts.
// Revision    : 1.0
// ============================================================================
module mcb_frame_writer #(
   parameter int DATA_W       = 64,
   parameter int MAX_BL       = 32,
   parameter int FRAME_WORDS  = 8820,
   parameter int BASE_A       = 0,
   parameter int BASE_B       = 70560,
   parameter int FLUSH_CYCLES = 255
) (
   input  wire logic             clk0,
   input  wire logic             reset,
   input  wire logic             calib_done,
   mcb_frame_writer_if.slave     bus,
   output logic                  disp_buf,
   output logic                  frame_done,
   output logic                  err_ovf
);

   localparam int BYTES   = DATA_W / 8;
   localparam int ADDR_SH = $clog2(BYTES);
   localparam int OFF_W   = $clog2(FRAME_WORDS + 1);

   typedef enum logic [1:0] {
      ST_CAL   = 2'd0,
      ST_FILL  = 2'd1,
      ST_CMD   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               cal_meta_q, cal_sync_q;
   logic [6:0]         cnt_q, cnt_d;
   logic [OFF_W-1:0]   word_off_q, word_off_d;
   logic               wr_buf_q, wr_buf_d;
   logic               disp_buf_q, disp_buf_d;
   logic               frame_done_q, frame_done_d;
   logic               err_ovf_q, err_ovf_d;
   logic               last_seen_q, last_seen_d;
   logic               close_q, close_d;
   logic               ovf_arm_q, ovf_arm_d;
   logic               wr_en_q, wr_en_d;
   logic [DATA_W-1:0]  wr_data_q, wr_data_d;

   logic [31:0]        w_rem;
   logic [31:0]        w_next_off;
   logic [6:0]         w_lim;
   logic               w_ready;
   logic               w_accept;
   logic               w_flush;
   logic [29:0]        w_base;

   always_ff @(posedge clk0 or posedge reset) begin
      if (reset) begin
         cal_meta_q <= 1'b0;
         cal_sync_q <= 1'b0;
      end else begin
         cal_meta_q <= calib_done;
         cal_sync_q <= cal_meta_q;
      end
   end

   assign w_rem      = 32'(FRAME_WORDS) - 32'(word_off_q);
   assign w_lim      = (w_rem < 32'(MAX_BL)) ? w_rem[6:0] : 7'(MAX_BL);
   assign w_next_off = 32'(word_off_q) + 32'(cnt_q);
   // Once src_last is in the burst, stop accepting so it closes with that word.
   assign w_ready    = (state_q == ST_FILL) && !bus.wr_full && !last_seen_q && (cnt_q < w_lim);
   assign w_accept   = w_ready && bus.src_valid;
   assign w_base     = wr_buf_q ? 30'(BASE_B) : 30'(BASE_A);

`ifdef MCB_FW_FLUSH_TIMEOUT_EN
   logic [7:0] idle_q;

   always_ff @(posedge clk0 or posedge reset) begin
      if (reset) begin
         idle_q <= 8'd0;
      end else if ((state_q != ST_FILL) || (cnt_q == 7'd0) || w_accept) begin
         idle_q <= 8'd0;
      end else if (idle_q != 8'(FLUSH_CYCLES)) begin
         idle_q <= idle_q + 8'd1;
      end
   end

   assign w_flush = (state_q == ST_FILL) && (cnt_q != 7'd0) && (idle_q == 8'(FLUSH_CYCLES));
`else
   assign w_flush = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      word_off_d   = word_off_q;
      wr_buf_d     = wr_buf_q;
      disp_buf_d   = disp_buf_q;
      frame_done_d = 1'b0;
      err_ovf_d    = err_ovf_q;
      last_seen_d  = last_seen_q;
      close_d      = close_q;
      ovf_arm_d    = ovf_arm_q;
      wr_en_d      = w_accept;
      wr_data_d    = w_accept ? bus.src_data : wr_data_q;

      case (state_q)
         ST_CAL: begin
            if (cal_sync_q) state_d = ST_FILL;
         end
         ST_FILL: begin
            if (w_accept) begin
               cnt_d = cnt_q + 7'd1;
               if (bus.src_last) last_seen_d = 1'b1;
               if (ovf_arm_q) begin
                  ovf_arm_d = 1'b0;
                  if (!bus.src_last) err_ovf_d = 1'b1;
               end
            // Wait for the last write to leave the pipeline before commanding.
            end else if ((cnt_q != 7'd0) && !wr_en_q &&
                         ((cnt_q == w_lim) || last_seen_q || w_flush)) begin
               state_d = ST_CMD;
            end
         end
         ST_CMD: begin
            word_off_d  = OFF_W'(w_next_off);
            cnt_d       = 7'd0;
            close_d     = last_seen_q || (w_next_off == 32'(FRAME_WORDS));
            ovf_arm_d   = (w_next_off == 32'(FRAME_WORDS)) && !last_seen_q;
            last_seen_d = 1'b0;
            state_d     = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (bus.wr_empty) begin
               state_d = ST_FILL;
               if (close_q) begin
                  disp_buf_d   = wr_buf_q;
                  wr_buf_d     = !wr_buf_q;
                  word_off_d   = '0;
                  frame_done_d = 1'b1;
                  close_d      = 1'b0;
               end
            end
         end
         default: state_d = ST_CAL;
      endcase
   end

   always_ff @(posedge clk0 or posedge reset) begin
      if (reset) begin
         state_q      <= ST_CAL;
         cnt_q        <= 7'd0;
         word_off_q   <= '0;
         wr_buf_q     <= 1'b0;
         disp_buf_q   <= 1'b1;
         frame_done_q <= 1'b0;
         err_ovf_q    <= 1'b0;
         last_seen_q  <= 1'b0;
         close_q      <= 1'b0;
         ovf_arm_q    <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         word_off_q   <= word_off_d;
         wr_buf_q     <= wr_buf_d;
         disp_buf_q   <= disp_buf_d;
         frame_done_q <= frame_done_d;
         err_ovf_q    <= err_ovf_d;
         last_seen_q  <= last_seen_d;
         close_q      <= close_d;
         ovf_arm_q    <= ovf_arm_d;
         wr_en_q      <= wr_en_d;
         wr_data_q    <= wr_data_d;
      end
   end

   assign bus.src_ready     = w_ready;
   assign bus.cmd_en        = (state_q == ST_CMD);
   assign bus.cmd_instr     = 3'b000;
   assign bus.cmd_bl        = (state_q == ST_CMD) ? 6'(cnt_q - 7'd1) : 6'd0;
   assign bus.cmd_byte_addr = (state_q == ST_CMD) ? (w_base + (30'(word_off_q) << ADDR_SH)) : 30'd0;
   assign bus.wr_en         = wr_en_q;
   assign bus.wr_data       = wr_data_q;
   assign bus.wr_mask       = '0;
   assign disp_buf          = disp_buf_q;
   assign frame_done        = frame_done_q;
   assign err_ovf           = err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mcb_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcb_frame_writer
// Description : Scoreboard bench for mcb_frame_writer (default parameters).
// Revision    : 1.0
// ============================================================================
module tb_mcb_frame_writer;

   localparam int DATA_W = 64;
   localparam int FW     = 8820;
   localparam int BASE_B = 70560;
   localparam int BUDGET = 400;

   typedef struct packed {
      logic [5:0]  bl;
      logic [29:0] addr;
   } cmd_t;

   logic clk0 = 1'b0;
   logic reset;
   logic calib_done;
   logic disp_buf, frame_done, err_ovf;

   mcb_frame_writer_if #(.DATA_W(DATA_W)) bus ();

   mcb_frame_writer #(.DATA_W(DATA_W)) dut (
      .clk0       (clk0),
      .reset      (reset),
      .calib_done (calib_done),
      .bus        (bus),
      .disp_buf   (disp_buf),
      .frame_done (frame_done),
      .err_ovf    (err_ovf)
   );

   always #5 clk0 = ~clk0;

   cmd_t              exp_cmd[$];
   logic [DATA_W-1:0] exp_data[$];
   cmd_t              e_cmd;
   logic [DATA_W-1:0] e_data;
   int n_vec = 0;
   int n_err = 0;
   int cmd_seen = 0;
   int fd_seen = 0;
   int cyc = 0;

   // One negedge step with the output monitor folded in.
   task automatic tick();
      @(negedge clk0);
      cyc++;
      if (!reset) begin
         if (bus.cmd_en) begin
            cmd_seen++;
            n_vec++;
            if (bus.wr_en) begin
               n_err++;
               $display("FAIL cmd_during_wr: cmd_en=1 wr_en=%0b, required wr_en=0", bus.wr_en);
            end else if (exp_cmd.size() == 0) begin
               n_err++;
               $display("FAIL cmd_unexpected: bl=%0d addr=%0d, required no command", bus.cmd_bl, bus.cmd_byte_addr);
            end else begin
               e_cmd = exp_cmd.pop_front();
               if (bus.cmd_bl !== e_cmd.bl || bus.cmd_byte_addr !== e_cmd.addr || bus.cmd_instr !== 3'b000) begin
                  n_err++;
                  $display("FAIL cmd: bl=%0d addr=%0d instr=%0d, required bl=%0d addr=%0d instr=0",
                           bus.cmd_bl, bus.cmd_byte_addr, bus.cmd_instr, e_cmd.bl, e_cmd.addr);
               end
            end
         end
         if (bus.wr_en) begin
            n_vec++;
            if (exp_data.size() == 0) begin
               n_err++;
               $display("FAIL wr_unexpected: data=%h, required no write", bus.wr_data);
            end else begin
               e_data = exp_data.pop_front();
               if (bus.wr_data !== e_data || bus.wr_mask !== 8'h00) begin
                  n_err++;
                  $display("FAIL wr_data: data=%h mask=%h, required data=%h mask=00", bus.wr_data, bus.wr_mask, e_data);
               end
            end
         end
         if (frame_done) fd_seen++;
      end
   endtask

   task automatic push_cmd(input int bl, input int addr);
      cmd_t c;
      c.bl   = 6'(bl);
      c.addr = 30'(addr);
      exp_cmd.push_back(c);
   endtask

   task automatic send_word(input logic [DATA_W-1:0] d, input logic last);
      int w;
      w = 0;
      bus.src_valid = 1'b1;
      bus.src_data  = d;
      bus.src_last  = last;
      while (!bus.src_ready && w < BUDGET) begin
         tick();
         w++;
      end
      n_vec++;
      if (w >= BUDGET) begin
         n_err++;
         $display("FAIL send_timeout: src_ready=0 after %0d cycles, required 1", w);
      end else begin
         exp_data.push_back(d);
         tick();
      end
      bus.src_valid = 1'b0;
      bus.src_last  = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int w;
      w = 0;
      while ((exp_cmd.size() != 0 || exp_data.size() != 0) && w < BUDGET) begin
         tick();
         w++;
      end
      n_vec++;
      if (w >= BUDGET) begin
         n_err++;
         $display("FAIL %s_drain: %0d cmds %0d words outstanding, required 0", name, exp_cmd.size(), exp_data.size());
         exp_cmd.delete();
         exp_data.delete();
      end
      repeat (4) tick();
   endtask

   function automatic logic [DATA_W-1:0] rnd();
      return {$urandom(), $urandom()};
   endfunction

   task automatic test_reset();
      #1;
      n_vec++;
      if (bus.src_ready !== 1'b0 || bus.cmd_en !== 1'b0 || bus.wr_en !== 1'b0 || bus.wr_data !== '0 ||
          bus.cmd_bl !== 6'd0 || bus.cmd_byte_addr !== 30'd0 || frame_done !== 1'b0 ||
          err_ovf !== 1'b0 || disp_buf !== 1'b1) begin
         n_err++;
         $display("FAIL reset_outputs: rdy=%0b cmd=%0b wr=%0b fd=%0b ovf=%0b disp=%0b, required 0 0 0 0 0 1",
                  bus.src_ready, bus.cmd_en, bus.wr_en, frame_done, err_ovf, disp_buf);
      end
   endtask

   task automatic test_calib();
      int viol, n;
      viol = 0;
      bus.src_valid = 1'b1;
      bus.src_data  = rnd();
      repeat (20) begin
         tick();
         if (bus.src_ready || bus.wr_en || bus.cmd_en) viol++;
      end
      n_vec++;
      if (viol != 0) begin
         n_err++;
         $display("FAIL calib_hold: %0d active cycles, required 0", viol);
      end
      calib_done = 1'b1;
      n = 0;
      while (!bus.src_ready && n < 10) begin
         tick();
         n++;
      end
      bus.src_valid = 1'b0;
      n_vec++;
      if (!bus.src_ready || n > 3) begin
         n_err++;
         $display("FAIL calib_ready: ready after %0d cycles, required <=3", n);
      end
   endtask

   task automatic test_bursts();
      push_cmd(31, 0);
      push_cmd(31, 256);
      for (int i = 0; i < 64; i++) send_word(rnd(), 1'b0);
      wait_idle("bursts");
   endtask

   task automatic test_last();
      int fd0;
      fd0 = fd_seen;
      push_cmd(4, 64 * 8);
      for (int i = 0; i < 5; i++) send_word(rnd(), (i == 4));
      wait_idle("last");
      n_vec++;
      if (fd_seen - fd0 != 1 || disp_buf !== 1'b0 || err_ovf !== 1'b0) begin
         n_err++;
         $display("FAIL last_close: pulses=%0d disp=%0b ovf=%0b, required 1 0 0", fd_seen - fd0, disp_buf, err_ovf);
      end
   endtask

   task automatic test_drain_stall();
      int c0, w, hi;
      bus.wr_empty = 1'b0;
      push_cmd(31, BASE_B);
      c0 = cmd_seen;
      for (int i = 0; i < 32; i++) send_word(rnd(), 1'b0);
      w = 0;
      while (cmd_seen == c0 && w < BUDGET) begin
         tick();
         w++;
      end
      n_vec++;
      if (cmd_seen == c0) begin
         n_err++;
         $display("FAIL stall_cmd: no command seen, required 1");
      end
      hi = 0;
      bus.src_valid = 1'b1;
      bus.src_data  = rnd();
      repeat (100) begin
         tick();
         if (bus.src_ready) hi++;
      end
      bus.src_valid = 1'b0;
      n_vec++;
      if (hi != 0) begin
         n_err++;
         $display("FAIL stall_ready: ready high %0d cycles, required 0", hi);
      end
      bus.wr_empty = 1'b1;
      wait_idle("stall");
   endtask

   task automatic test_flush();
      int c0, t0, c_at;
      c0   = cmd_seen;
      c_at = -1;
`ifdef MCB_FW_FLUSH_TIMEOUT_EN
      push_cmd(2, BASE_B + 32 * 8);
`endif
      for (int i = 0; i < 3; i++) send_word(rnd(), 1'b0);
      t0 = cyc;
      repeat (300) begin
         tick();
         if (cmd_seen != c0 && c_at < 0) c_at = cyc - t0;
      end
      n_vec++;
`ifdef MCB_FW_FLUSH_TIMEOUT_EN
      if (c_at < 250 || c_at > 262) begin
         n_err++;
         $display("FAIL flush_time: cmd after %0d idle cycles, required ~256", c_at);
      end
      push_cmd(0, BASE_B + 35 * 8);
`else
      if (c_at >= 0) begin
         n_err++;
         $display("FAIL flush_none: cmd after %0d idle cycles, required none", c_at);
      end
      push_cmd(3, BASE_B + 32 * 8);
`endif
      send_word(rnd(), 1'b1);
      wait_idle("flush");
      n_vec++;
      if (disp_buf !== 1'b1) begin
         n_err++;
         $display("FAIL flush_disp: disp_buf=%0b, required 1", disp_buf);
      end
   endtask

   task automatic test_full_frame();
      int fd0;
      fd0 = fd_seen;
      for (int off = 0; off < FW; off += 32) begin
         int n;
         n = (FW - off < 32) ? (FW - off) : 32;
         push_cmd(n - 1, off * 8);
      end
      for (int i = 0; i < FW; i++) send_word(rnd(), 1'b0);
      wait_idle("full");
      n_vec++;
      if (fd_seen - fd0 != 1 || disp_buf !== 1'b0 || err_ovf !== 1'b0) begin
         n_err++;
         $display("FAIL full_close: pulses=%0d disp=%0b ovf=%0b, required 1 0 0", fd_seen - fd0, disp_buf, err_ovf);
      end
      send_word(rnd(), 1'b0);
      tick();
      n_vec++;
      if (err_ovf !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_set: err_ovf=%0b, required 1", err_ovf);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 9; i++) send_word(rnd(), 1'b0);
      repeat (2) tick();
      reset = 1'b1;
      test_reset();
      repeat (3) tick();
      reset = 1'b0;
      push_cmd(31, 0);
      for (int i = 0; i < 32; i++) send_word(rnd(), 1'b0);
      wait_idle("post_reset");
      n_vec++;
      if (err_ovf !== 1'b0 || disp_buf !== 1'b1) begin
         n_err++;
         $display("FAIL post_reset_flags: ovf=%0b disp=%0b, required 0 1", err_ovf, disp_buf);
      end
   endtask

   initial begin
      reset         = 1'b1;
      calib_done    = 1'b0;
      bus.src_valid = 1'b0;
      bus.src_data  = '0;
      bus.src_last  = 1'b0;
      bus.wr_full   = 1'b0;
      bus.wr_empty  = 1'b1;
      repeat (3) tick();
      test_reset();
      reset = 1'b0;
      test_calib();
      test_bursts();
      test_last();
      test_drain_stall();
      test_flush();
      test_full_frame();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
